// File: rtl/fetch_sequencer.sv
// Fetch/decode sequencer for the 8-bit core.
// Drives the program counter (reset / increment / load), latches instructions, resolves
// JMP, JZ and HALT locally and issues every other opcode to the datapath via exec_valid/exec_done.
// Optional return-address stack (CALL/RET) is enabled by defining FETCH_CALL_STACK_EN.
module fetch_sequencer #(
  parameter int unsigned prog_mem_length = 8,
  parameter int unsigned INSTR_W         = 16,
  parameter int unsigned MEM_LAT         = 1,
  parameter int unsigned STACK_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [prog_mem_length-1:0] pc,
  input  logic [INSTR_W-1:0]         instr,
  input  logic                       zero_flag,
  input  logic                       exec_done,
  output logic                       rstPC,
  output logic                       cePC,
  output logic                       wrJumpAdr,
  output logic [prog_mem_length-1:0] jumpAdr,
  output logic [INSTR_W-1:0]         ir,
  output logic                       exec_valid,
  output logic                       busy,
  output logic                       halted,
  output logic                       err,
  output logic [15:0]                instr_cnt
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [3:0] OpHalt = 4'hF;
  localparam logic [3:0] OpJmp  = 4'hE;
  localparam logic [3:0] OpJz   = 4'hB;

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StNext, StHalt} state_e;

  state_e                     state_q, state_d;
  logic [LatW-1:0]            lat_q, lat_d;
  logic [INSTR_W-1:0]         ir_q, ir_d;
  logic                       rst_pc_q, rst_pc_d;
  logic                       ce_q, ce_d;
  logic                       wr_q, wr_d;
  logic [prog_mem_length-1:0] adr_q, adr_d;
  logic [15:0]                cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic                       exec_valid_q, busy_q, halted_q;

  logic [3:0]                 opcode;
  logic [prog_mem_length-1:0] target;

  assign opcode = ir_q[INSTR_W-1 -: 4];
  assign target = ir_q[prog_mem_length-1:0];

`ifdef FETCH_CALL_STACK_EN
  localparam logic [3:0] OpRet  = 4'hC;
  localparam logic [3:0] OpCall = 4'hD;
  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [prog_mem_length-1:0] stack_q [STACK_DEPTH];
  logic [SpW-1:0]             sp_q;
  logic                       push, pop;

  // Return-address stack; entries need no reset, only the pointer does.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else if (push) begin
      stack_q[IdxW'(sp_q)] <= pc + 1'b1;
      sp_q                 <= sp_q + 1'b1;
    end else if (pop) begin
      sp_q <= sp_q - 1'b1;
    end
  end
`else
  // pc is only needed for CALL return addresses.
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  // Next-state and next-output logic; pulse outputs are registered from these.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    ir_d     = ir_q;
    rst_pc_d = 1'b0;
    ce_d     = 1'b0;
    wr_d     = 1'b0;
    adr_d    = adr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
`ifdef FETCH_CALL_STACK_EN
    push     = 1'b0;
    pop      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rst_pc_d = 1'b1;
          lat_d    = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        // Hold off counting while the PC reset pulse is still being applied.
        if (!rst_pc_q) begin
          if (lat_q == LatW'(MEM_LAT - 1)) begin
            ir_d    = instr;
            lat_d   = '0;
            state_d = StDecode;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
      end
      StDecode: begin
        case (opcode)
          OpHalt: state_d = StHalt;
          OpJmp: begin
            wr_d    = 1'b1;
            adr_d   = target;
            state_d = StNext;
          end
          OpJz: begin
            if (zero_flag) begin
              wr_d  = 1'b1;
              adr_d = target;
            end else begin
              ce_d = 1'b1;
            end
            state_d = StNext;
          end
`ifdef FETCH_CALL_STACK_EN
          OpCall: begin
            if (sp_q == SpW'(STACK_DEPTH)) begin
              err_d   = 1'b1;
              state_d = StHalt;
            end else begin
              push    = 1'b1;
              wr_d    = 1'b1;
              adr_d   = target;
              state_d = StNext;
            end
          end
          OpRet: begin
            if (sp_q == '0) begin
              err_d   = 1'b1;
              state_d = StHalt;
            end else begin
              pop     = 1'b1;
              wr_d    = 1'b1;
              adr_d   = stack_q[IdxW'(sp_q - 1'b1)];
              state_d = StNext;
            end
          end
`endif
          default: state_d = StExec;
        endcase
      end
      StExec: begin
        if (exec_done) begin
          ce_d    = 1'b1;
          state_d = StNext;
        end
      end
      StNext: begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        state_d = StFetch;
      end
      StHalt: begin
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; synchronous reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lat_q        <= '0;
      ir_q         <= '0;
      rst_pc_q     <= 1'b0;
      ce_q         <= 1'b0;
      wr_q         <= 1'b0;
      adr_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      exec_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      ir_q         <= ir_d;
      rst_pc_q     <= rst_pc_d;
      ce_q         <= ce_d;
      wr_q         <= wr_d;
      adr_q        <= adr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      exec_valid_q <= (state_d == StExec);
      busy_q       <= (state_d != StIdle) && (state_d != StHalt);
      halted_q     <= (state_d == StHalt);
    end
  end

  assign rstPC      = rst_pc_q;
  assign cePC       = ce_q;
  assign wrJumpAdr  = wr_q;
  assign jumpAdr    = adr_q;
  assign ir         = ir_q;
  assign exec_valid = exec_valid_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign instr_cnt  = cnt_q;
`ifdef FETCH_CALL_STACK_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: table vectors, directed multi-cycle sequences and random
// programs checked against an instruction-level model of PC flow, retire count and timing.
module tb_fetch_sequencer;

  localparam int unsigned AW     = 8;
  localparam int unsigned IW     = 16;
  localparam int unsigned MemLat = 3;
  localparam int unsigned Depth  = 4;

  logic          clk = 1'b0;
  logic          rst, start, zero_flag, exec_done;
  logic [AW-1:0] pc, jumpAdr;
  logic [IW-1:0] instr, ir;
  logic          rstPC, cePC, wrJumpAdr, exec_valid, busy, halted, err;
  logic [15:0]   instr_cnt;
  logic [IW-1:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer #(
    .prog_mem_length(AW),
    .INSTR_W        (IW),
    .MEM_LAT        (MemLat),
    .STACK_DEPTH    (Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc        (pc),
    .instr     (instr),
    .zero_flag (zero_flag),
    .exec_done (exec_done),
    .rstPC     (rstPC),
    .cePC      (cePC),
    .wrJumpAdr (wrJumpAdr),
    .jumpAdr   (jumpAdr),
    .ir        (ir),
    .exec_valid(exec_valid),
    .busy      (busy),
    .halted    (halted),
    .err       (err),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  // Environment: program counter and program memory.
  always @(posedge clk) begin
    if (rstPC) pc <= '0;
    else if (wrJumpAdr) pc <= jumpAdr;
    else if (cePC) pc <= pc + 8'd1;
  end
  assign instr = mem[pc];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Datapath responder: raises exec_done after exec_delay cycles of exec_valid.
  int exec_delay = 0, exec_k = 0, last_exec_cycles = 1;
  bit rand_delay = 0;
  initial begin
    exec_done = 1'b0;
    forever begin
      @(negedge clk);
      if (exec_valid) begin
        exec_done = (exec_k == exec_delay);
        if (exec_done) begin
          last_exec_cycles = exec_k + 1;
          if (rand_delay) exec_delay = $urandom_range(0, 4);
        end
        exec_k++;
      end else begin
        exec_k    = 0;
        exec_done = 1'b0;
      end
    end
  end

  // Instruction-level reference model, advanced at each PC pulse.
  int         cyc = 0, model_cnt = 0, n_rst = 0, n_ce = 0, n_wr = 0, n_valid = 0, exp_d;
  logic [7:0] model_pc = '0, tgt;
  logic [3:0] op;
  bit         jump, is_exec, halted_prev = 0, rand_zero = 0, halt_ok;
  logic [7:0] stk [$];
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exec_valid) n_valid++;
      if (rst) begin
        model_cnt = 0;
        cyc       = 0;
      end else if (rstPC) begin
        n_rst++;
        model_pc = '0;
        cyc      = 0;
        stk.delete();
      end else if (cePC || wrJumpAdr) begin
        op      = mem[model_pc][15:12];
        tgt     = mem[model_pc][7:0];
        jump    = 1'b0;
        is_exec = 1'b1;
        if (op == 4'hE) begin
          jump = 1'b1; is_exec = 1'b0;
        end else if (op == 4'hB) begin
          jump = zero_flag; is_exec = 1'b0;
        end
`ifdef FETCH_CALL_STACK_EN
        else if (op == 4'hD) begin
          jump = 1'b1; is_exec = 1'b0; stk.push_back(model_pc + 8'd1);
        end else if (op == 4'hC) begin
          jump = 1'b1; is_exec = 1'b0; tgt = stk.pop_back();
        end
`endif
        exp_d = is_exec ? MemLat + 2 + last_exec_cycles : MemLat + 2;
        check("pulse exclusive", cePC & wrJumpAdr, 0);
        check("pulse pc", pc, model_pc);
        check("pulse load", wrJumpAdr, jump);
        check("pulse incr", cePC, !jump);
        if (jump) check("pulse jumpAdr", jumpAdr, tgt);
        check("pulse spacing", cyc, exp_d);
        check("pulse instr_cnt", instr_cnt, model_cnt);
        if (wrJumpAdr) n_wr++;
        if (cePC) n_ce++;
        if (model_cnt < 16'hFFFF) model_cnt++;
        model_pc = jump ? tgt : model_pc + 8'd1;
        cyc      = 0;
        if (rand_zero) zero_flag = 1'($urandom_range(0, 1));
      end
      if (!rst && halted && !halted_prev) begin
        op      = mem[model_pc][15:12];
        halt_ok = (op == 4'hF);
`ifdef FETCH_CALL_STACK_EN
        halt_ok = halt_ok || (op == 4'hD && stk.size() == Depth) || (op == 4'hC && stk.size() == 0);
`endif
        check("halt cause", halt_ok, 1);
        check("halt latency", cyc, MemLat + 2);
      end
      halted_prev = halted;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    bit ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (halted) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    check({name, " ctl"}, {rstPC, cePC, wrJumpAdr, exec_valid, busy, halted, err}, 0);
    check({name, " ir"}, ir, 0);
    check({name, " jumpAdr"}, jumpAdr, 0);
    check({name, " instr_cnt"}, instr_cnt, 0);
  endtask

  task automatic fill_mem(input logic [15:0] w);
    for (int a = 0; a < 256; a++) mem[a] = w;
  endtask

  typedef struct {
    logic [15:0] instr0;
    bit          zf;
    bit          exp_halt;
    bit          exp_jump;
    logic [7:0]  exp_adr;
    logic [7:0]  exp_pc;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];
  int   nvec;

  initial begin
    rst = 1'b0; start = 1'b0; zero_flag = 1'b0;
    fill_mem(16'hF000);
    do_reset();
    check_reset_state("reset");

    // Table vectors: one instruction at address 0, HALT everywhere else.
    vecs[0] = '{16'hE040, 1'b0, 1'b0, 1'b1, 8'h40, 8'h40, 16'd1};
    vecs[1] = '{16'hB010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 16'd1};
    vecs[2] = '{16'hB010, 1'b1, 1'b0, 1'b1, 8'h10, 8'h10, 16'd1};
    vecs[3] = '{16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 16'd1};
    vecs[4] = '{16'hF000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 16'd0};
    vecs[5] = '{16'hA0FF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 16'd1};
    nvec = 6;
`ifndef FETCH_CALL_STACK_EN
    vecs[6] = '{16'hC005, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 16'd1};
    vecs[7] = '{16'hD007, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 16'd1};
    nvec = 8;
`endif
    exec_delay = 0;
    for (int i = 0; i < nvec; i++) begin
      bit ok = 0;
      fill_mem(16'hF000);
      mem[0]    = vecs[i].instr0;
      zero_flag = vecs[i].zf;
      do_reset();
      do_start();
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (cePC || wrJumpAdr || halted) begin ok = 1; break; end
      end
      check($sformatf("vec%0d event", i), ok, 1);
      if (vecs[i].exp_halt) begin
        check($sformatf("vec%0d halted", i), halted, 1);
        check($sformatf("vec%0d no pulse", i), cePC | wrJumpAdr, 0);
      end else begin
        check($sformatf("vec%0d wr", i), wrJumpAdr, vecs[i].exp_jump);
        check($sformatf("vec%0d ce", i), cePC, !vecs[i].exp_jump);
        if (vecs[i].exp_jump) check($sformatf("vec%0d adr", i), jumpAdr, vecs[i].exp_adr);
      end
      wait_halt($sformatf("vec%0d halt reached", i), 40);
      check($sformatf("vec%0d cnt", i), instr_cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d ir", i), ir, 16'hF000);
      check($sformatf("vec%0d busy", i), busy, 0);
    end

    // Three ALU ops then HALT, done one cycle after valid.
    fill_mem(16'hF000);
    mem[0] = 16'h1000; mem[1] = 16'h2000; mem[2] = 16'h3000;
    exec_delay = 1;
    do_reset();
    n_rst = 0; n_ce = 0; n_wr = 0;
    do_start();
    wait_halt("seq1 halt", 100);
    check("seq1 rstPC pulses", n_rst, 1);
    check("seq1 cePC pulses", n_ce, 3);
    check("seq1 wr pulses", n_wr, 0);
    check("seq1 instr_cnt", instr_cnt, 3);
    // HALT is sticky: start is ignored.
    do_start();
    repeat (5) @(negedge clk);
    check("halt sticky", halted, 1);
    check("halt ignores start", n_rst, 1);
    do_reset();
    check_reset_state("reset after halt");

    // Long datapath op: done held low 5 cycles.
    fill_mem(16'hF000);
    mem[0] = 16'h1000;
    exec_delay = 5;
    do_reset();
    n_valid = 0; n_ce = 0;
    do_start();
    wait_halt("seq4 halt", 100);
    check("seq4 valid cycles", n_valid, 6);
    check("seq4 cePC pulses", n_ce, 1);

    // Reset in the middle of EXEC, then restart.
    begin
      bit ok = 0;
      fill_mem(16'hF000);
      mem[0] = 16'h1000; mem[1] = 16'h2000;
      exec_delay = 20;
      do_reset();
      do_start();
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (exec_valid) begin ok = 1; break; end
      end
      check("seq5 valid seen", ok, 1);
      repeat (2) @(negedge clk);
      n_ce = 0; n_wr = 0; n_rst = 0;
      do_reset();
      @(negedge clk);
      check("seq5 valid dropped", exec_valid, 0);
      check("seq5 cnt cleared", instr_cnt, 0);
      check("seq5 busy", busy, 0);
      repeat (4) @(negedge clk);
      check("seq5 no pc pulse", n_ce + n_wr, 0);
      exec_delay = 1;
      do_start();
      wait_halt("seq5 halt", 100);
      check("seq5 rstPC pulses", n_rst, 1);
      check("seq5 instr_cnt", instr_cnt, 2);
    end

`ifdef FETCH_CALL_STACK_EN
    // CALL/RET round trip, then RET on an empty stack.
    fill_mem(16'hF000);
    mem[0] = 16'hE005; mem[5] = 16'hD020; mem[8'h20] = 16'hC000; mem[6] = 16'hC000;
    do_reset();
    do_start();
    wait_halt("seq6 halt", 200);
    check("seq6 err", err, 1);
    check("seq6 instr_cnt", instr_cnt, 3);
    check("seq6 pc", pc, 8'h06);
`endif

    // Random programs against the model.
    rand_delay = 1; rand_zero = 1;
    for (int p = 0; p < 3; p++) begin
      for (int a = 0; a < 256; a++) begin
        int k = $urandom_range(0, 99);
        logic [3:0] rop;
        if (k < 6) rop = 4'hF;
        else if (k < 18) rop = 4'hE;
        else if (k < 32) rop = 4'hB;
        else rop = 4'($urandom_range(0, 10));
        mem[a] = {rop, 4'($urandom), 8'($urandom)};
      end
      exec_delay = $urandom_range(0, 4);
      zero_flag  = 1'($urandom_range(0, 1));
      do_reset();
      do_start();
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (halted) break;
      end
      if (halted) check($sformatf("rand%0d final cnt", p), instr_cnt, model_cnt);
    end
    rand_delay = 0; rand_zero = 0;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
